// File: rtl/pulse_burst_scheduler_pkg.sv
// Shared types and default widths for the pulse burst scheduler.
package pulse_burst_pkg;

  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_MISS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    EMIT,
    GAP
  } state_e;

endpackage

// File: rtl/pulse_burst_scheduler_if.sv
// Trigger/config inputs and strobe/status outputs of the burst scheduler.
interface pulse_burst_scheduler_if
  import pulse_burst_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MISS_WIDTH = DEF_MISS_WIDTH
);

  logic                  enable;
  logic                  trig;
  logic [CNT_WIDTH-1:0]  delay;
  logic [CNT_WIDTH-1:0]  period;
  logic [CNT_WIDTH-1:0]  count;
  logic                  pulse;
  logic                  busy;
  logic                  done;
  logic [MISS_WIDTH-1:0] miss_count;

  modport master (
    output enable, trig, delay, period, count,
    input  pulse, busy, done, miss_count
  );

  modport slave (
    input  enable, trig, delay, period, count,
    output pulse, busy, done, miss_count
  );

endinterface

// File: rtl/pulse_burst_scheduler_trig_edge_detect.sv
// Rising-edge detector on the level trigger; edge strobe is combinational from trig.
module trig_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_trig,
  output logic o_edge
);

  logic r_trig_prev;

  // NOTE: resets high so a trigger held high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!resetn) r_trig_prev <= 1'b1;
    else         r_trig_prev <= i_trig;
  end

  assign o_edge = i_trig & ~r_trig_prev;

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Turns one trigger edge into a delayed burst of evenly spaced single-cycle pulses,
// counting triggers that arrive while a burst is running.
module pulse_burst_scheduler
  import pulse_burst_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MISS_WIDTH = DEF_MISS_WIDTH
) (
  input logic                    clk,
  input logic                    resetn,
  pulse_burst_scheduler_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_period;
  logic [CNT_WIDTH-1:0]  r_remain;
  logic [CNT_WIDTH-1:0]  r_timer;
  logic                  r_pulse;
  logic                  r_busy;
  logic                  r_done;
  logic [MISS_WIDTH-1:0] r_miss;

  logic                  w_edge;
  logic [CNT_WIDTH-1:0]  w_period_eff;

  trig_edge_detect u_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_trig (bus.trig),
    .o_edge (w_edge)
  );

  assign w_period_eff = (bus.period == '0) ? ONE : bus.period;

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_remain <= '0;
      r_timer  <= '0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_miss   <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;

      if (w_edge && (r_state != IDLE) && !(&r_miss))
        r_miss <= r_miss + MISS_WIDTH'(1);

      // Abort wins over everything, including the completing pulse's done.
      if ((r_state != IDLE) && !bus.enable) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_edge && bus.enable && (bus.count != '0)) begin
              r_period <= w_period_eff;
              r_remain <= bus.count;
              r_busy   <= 1'b1;
              if (bus.delay != '0) begin
                r_state <= DELAY;
                r_timer <= bus.delay - ONE;
              end else begin
                r_state <= EMIT;
                r_pulse <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (r_timer == '0) begin
              r_state <= EMIT;
              r_pulse <= 1'b1;
            end else begin
              r_timer <= r_timer - ONE;
            end
          end
          EMIT: begin
            r_remain <= r_remain - ONE;
            if (r_remain == ONE) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_period == ONE) begin
              r_pulse <= 1'b1;
            end else begin
              r_state <= GAP;
              r_timer <= r_period - TWO;
            end
          end
          GAP: begin
            if (r_timer == '0) begin
              r_state <= EMIT;
              r_pulse <= 1'b1;
            end else begin
              r_timer <= r_timer - ONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pulse      = r_pulse;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.miss_count = r_miss;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Scoreboard bench: a timeline model predicts pulse/done cycles, busy and miss count.
module tb_pulse_burst_scheduler;

  localparam int CW       = 32;
  localparam int MW       = 4;
  localparam int MISS_MAX = (1 << MW) - 1;

  typedef struct {
    int c;
    bit busy;
    int miss;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  pulse_burst_scheduler_if #(.CNT_WIDTH(CW), .MISS_WIDTH(MW)) bus ();

  pulse_burst_scheduler #(.CNT_WIDTH(CW), .MISS_WIDTH(MW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Stimulus variables
  logic          t_rst_n, t_en, t_trig;
  logic [CW-1:0] t_delay, t_period, t_count;

  // Model state
  int   cyc;
  bit   m_prev;
  bit   m_active;
  int   m_e, m_l;
  int   mc;
  int   exp_pulse[$];
  int   exp_done[$];
  exp_t exp_st[$];

  int   n_cmp, n_bad;
  bit   mon_on;
  int   e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Drop every predicted event later than cycle n (abort or reset).
  task automatic prune(input int n);
    while (exp_pulse.size() > 0 && exp_pulse[$] > n) void'(exp_pulse.pop_back());
    while (exp_done.size() > 0 && exp_done[$] > n) void'(exp_done.pop_back());
  endtask

  // Inputs applied during cycle n decide outputs visible in cycle n+1.
  task automatic model(input int n);
    bit   edge_s, busy_now;
    int   d, p, k, cnt;
    exp_t x;
    edge_s   = t_trig && !m_prev;
    busy_now = m_active && (n > m_e) && (n <= m_l);
    if (!t_rst_n) begin
      m_active = 0;
      mc       = 0;
      prune(n);
    end else begin
      if (busy_now && edge_s && mc < MISS_MAX) mc++;
      if (busy_now && !t_en) begin
        prune(n);
        m_active = 0;
      end else if (!busy_now && edge_s && t_en && t_count != 0) begin
        d   = int'(t_delay);
        p   = (t_period == 0) ? 1 : int'(t_period);
        cnt = int'(t_count);
        for (k = 0; k < cnt; k++) exp_pulse.push_back(n + 1 + d + k * p);
        m_e      = n;
        m_l      = n + 1 + d + (cnt - 1) * p;
        m_active = 1;
        exp_done.push_back(m_l + 1);
      end
    end
    m_prev = t_rst_n ? t_trig : 1'b1;
    x.c    = n + 1;
    x.busy = m_active && (n + 1 > m_e) && (n + 1 <= m_l);
    x.miss = mc;
    exp_st.push_back(x);
  endtask

  task automatic apply();
    resetn     = t_rst_n;
    bus.enable = t_en;
    bus.trig   = t_trig;
    bus.delay  = t_delay;
    bus.period = t_period;
    bus.count  = t_count;
    model(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    apply();
  endtask

  task automatic fire();
    t_trig = 1'b1;
    step();
    t_trig = 1'b0;
    step();
  endtask

  // Monitor: pops expectations as the DUT presents outputs each cycle.
  always @(negedge clk) begin
    exp_t x;
    if (mon_on) begin
      if (exp_st.size() == 0 || exp_st[0].c != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL state_sync at cycle %0d: no expectation queued", cyc);
      end else begin
        x = exp_st.pop_front();
        check("busy", 32'(bus.busy), 32'(x.busy));
        check("miss_count", 32'(bus.miss_count), 32'(x.miss));
      end

      while (exp_pulse.size() > 0 && exp_pulse[0] < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_missing: got none, expected pulse at cycle %0d", exp_pulse.pop_front());
      end
      if (bus.pulse === 1'b1) begin
        n_cmp++;
        if (exp_pulse.size() > 0 && exp_pulse[0] == cyc) void'(exp_pulse.pop_front());
        else begin
          n_bad++;
          $display("FAIL pulse_unexpected: got pulse at cycle %0d, expected none", cyc);
        end
      end

      while (exp_done.size() > 0 && exp_done[0] < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_missing: got none, expected done at cycle %0d", exp_done.pop_front());
      end
      if (bus.done === 1'b1) begin
        n_cmp++;
        if (exp_done.size() > 0 && exp_done[0] == cyc) void'(exp_done.pop_front());
        else begin
          n_bad++;
          $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_prev = 1'b1; m_active = 0; m_e = 0; m_l = 0; mc = 0;
    t_rst_n = 1'b0; t_en = 1'b1; t_trig = 1'b1;
    t_delay = '0; t_period = '0; t_count = 32'd1;
    apply();
    mon_on = 1'b1;

    // Trigger held high through reset release must not fire.
    repeat (3) step();
    t_rst_n = 1'b1;
    repeat (4) step();

    // Basic burst: delay 3, period 4, count 3.
    t_delay = 32'd3; t_period = 32'd4; t_count = 32'd3;
    t_trig = 1'b0; step();
    t_trig = 1'b1; step();
    t_trig = 1'b0; repeat (16) step();

    // Zero delay and zero period: back-to-back pulses.
    t_delay = 32'd0; t_period = 32'd0; t_count = 32'd5;
    fire(); repeat (8) step();

    // Zero count: trigger ignored.
    t_count = 32'd0;
    fire(); repeat (3) step();

    // Retrigger: three rejected edges, then one exactly on the done cycle.
    t_delay = 32'd0; t_period = 32'd10; t_count = 32'd4;
    fire();
    e = cyc - 1;
    repeat (3) begin
      repeat (6) step();
      fire();
    end
    while (cyc < e + 31) step();
    fire();
    repeat (35) step();

    // Abort after the second pulse.
    t_delay = 32'd2; t_period = 32'd3; t_count = 32'd5;
    fire();
    e = cyc - 1;
    while (cyc < e + 6) step();
    t_en = 1'b0;
    repeat (6) step();
    t_en = 1'b1;
    repeat (20) step();

    // Reset in the middle of a burst.
    t_delay = 32'd1; t_period = 32'd2; t_count = 32'd6;
    fire(); repeat (4) step();
    t_rst_n = 1'b0; step();
    t_rst_n = 1'b1; repeat (16) step();

    // Miss counter saturation: twenty edges during one long delay.
    t_delay = 32'd60; t_period = 32'd1; t_count = 32'd1;
    fire();
    repeat (20) fire();
    repeat (30) step();

    // Randomized traffic.
    repeat (400) begin
      t_rst_n  = ($urandom_range(99) != 0);
      t_en     = ($urandom_range(9) != 0);
      t_trig   = ($urandom_range(3) == 0);
      t_delay  = CW'($urandom_range(6));
      t_period = CW'($urandom_range(5));
      t_count  = CW'($urandom_range(5));
      step();
    end

    t_rst_n = 1'b1; t_en = 1'b1; t_trig = 1'b0;
    repeat (40) step();
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("leftover_pulses", 32'(exp_pulse.size()), 32'd0);
    check("leftover_done", 32'(exp_done.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
